// File: rtl/iob_arb_pkg.sv
// Shared definitions for the IOb memory arbiter: FSM state encoding and the
// width helper for requester index signals.
package iob_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Width of a requester index; never below 1 so a vector can be declared.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker.
// Scans requesters starting at last_i+1 (mod N_REQ) and returns the first one
// that is asserting a request.
//   req_i   : per-requester request bits
//   last_i  : index of the previously served requester
//   grant_o : index of the chosen requester (meaningful only when found_o)
//   found_o : at least one request present
module iob_rr_pick
    import iob_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned SEL_W = sel_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             found_o
);

    int unsigned          start;
    int unsigned          off;
    int unsigned          idx;
    logic [2*N_REQ-1:0]   rot;

    always_comb begin
        start   = (32'(last_i) + 32'd1) % N_REQ;
        // Doubling the vector lets a plain right shift act as a rotate.
        rot     = {req_i, req_i} >> start;
        off     = 0;
        found_o = 1'b0;
        // Descending loop: the lowest set bit is the last one assigned.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = i;
                found_o = 1'b1;
            end
        end
        idx     = (start + off) % N_REQ;
        grant_o = SEL_W'(idx);
    end

endmodule

// File: rtl/iob_ethmac_mem_arbiter.sv
// Shares one IOb memory port between N_REQ IOb masters (index 0 is the
// ethernet MAC DMA). Round-robin, one outstanding transaction at a time; the
// grant is held until the memory signals m_ready.
//   clk, rst_n                     : clock, async active-low reset
//   s_valid/s_addr/s_wdata/s_wstrb : packed per-requester request fields
//   s_rdata, s_ready               : shared read data, one-hot completion pulse
//   m_valid/m_addr/m_wdata/m_wstrb : registered request to memory
//   m_rdata, m_ready               : memory response
//   grant_o                        : current/last owner index (debug)
module iob_ethmac_mem_arbiter
    import iob_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 2,
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned SEL_W  = sel_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          s_valid,
    input  logic [N_REQ*ADDR_W-1:0]   s_addr,
    input  logic [N_REQ*DATA_W-1:0]   s_wdata,
    input  logic [N_REQ*STRB_W-1:0]   s_wstrb,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [N_REQ-1:0]          s_ready,
    output logic                      m_valid,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [STRB_W-1:0]         m_wstrb,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_ready,
    output logic [SEL_W-1:0]          grant_o
);

    localparam logic [SEL_W-1:0] LastInit = SEL_W'(N_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic [SEL_W-1:0]    pick_idx;
    logic                pick_found;

    iob_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (s_valid),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        s_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx;
                    addr_d  = s_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = s_wdata[pick_idx*DATA_W +: DATA_W];
                    wstrb_d = s_wstrb[pick_idx*STRB_W +: STRB_W];
                end
            end
            ST_BUSY: begin
                // Completion is combinational from m_ready; fields stay latched
                // even if the owner drops s_valid mid-transaction.
                if (m_ready) begin
                    s_ready[grant_q] = 1'b1;
                    last_d           = grant_q;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= LastInit;
            last_q  <= LastInit;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign m_valid = (state_q == ST_BUSY);
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_wstrb = wstrb_q;
    assign s_rdata = m_rdata;
    assign grant_o = grant_q;

endmodule
